// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between the instruction-fetch port
// and the MEM-stage load/store port. The grant FSM is round-robin on
// contention. Acks are one-cycle pulses, and read data is held in registers.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort bus waits after
// TIMEOUT_CYCLES cycles without m_ready. An abort sets the sticky err flag.
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ce,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_ce,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        m_ce,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_sel,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        stallreq_if,
  output logic        stallreq_mem,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t      state_reg;
  logic        last_grant_reg;
  logic        i_ack_reg;
  logic        d_ack_reg;
  logic [31:0] i_rdata_reg;
  logic [31:0] d_rdata_reg;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  // The last wait cycle before abort is the one where the count would reach TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             err_reg;
`endif

  // Grant FSM: arbitrate in IDLE, then hold the grant until m_ready (or a timeout).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= GRANT_I;
      i_ack_reg      <= 1'b0;
      d_ack_reg      <= 1'b0;
      i_rdata_reg    <= 32'd0;
      d_rdata_reg    <= 32'd0;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_cnt_reg   <= '0;
      err_reg        <= 1'b0;
`endif
    end else begin
      i_ack_reg <= 1'b0;
      d_ack_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
          wait_cnt_reg <= '0;
`endif
          // On contention the port that did not win last time gets the bus.
          if (d_ce && (!i_ce || last_grant_reg == GRANT_I)) begin
            state_reg <= DGRANT;
          end else if (i_ce) begin
            state_reg <= IGRANT;
          end
        end
        DGRANT, IGRANT: begin
          if (m_ready) begin
            if (state_reg == DGRANT) begin
              d_ack_reg      <= 1'b1;
              last_grant_reg <= GRANT_D;
              // Stores complete with an ack but leave the load-data register alone.
              if (!d_we) begin
                d_rdata_reg <= m_rdata;
              end
            end else begin
              i_ack_reg      <= 1'b1;
              last_grant_reg <= GRANT_I;
              i_rdata_reg    <= m_rdata;
            end
            state_reg <= IDLE;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (wait_cnt_reg == WAIT_LAST) begin
            // Abort: complete the access with zero data so the pipeline can proceed.
            if (state_reg == DGRANT) begin
              d_ack_reg      <= 1'b1;
              d_rdata_reg    <= 32'd0;
              last_grant_reg <= GRANT_D;
            end else begin
              i_ack_reg      <= 1'b1;
              i_rdata_reg    <= 32'd0;
              last_grant_reg <= GRANT_I;
            end
            err_reg   <= 1'b1;
            state_reg <= IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Bus mux: the granted port drives the shared bus, and IDLE drives all zeros.
  always_comb begin
    m_ce    = 1'b0;
    m_we    = 1'b0;
    m_addr  = 32'd0;
    m_sel   = 4'd0;
    m_wdata = 32'd0;
    case (state_reg)
      DGRANT: begin
        m_ce    = 1'b1;
        m_we    = d_we;
        m_addr  = d_addr;
        m_sel   = d_sel;
        m_wdata = d_wdata;
      end
      IGRANT: begin
        m_ce   = 1'b1;
        m_sel  = 4'b1111;
        m_addr = i_addr;
      end
      default: ;
    endcase
  end

  assign i_ack        = i_ack_reg;
  assign d_ack        = d_ack_reg;
  assign i_rdata      = i_rdata_reg;
  assign d_rdata      = d_rdata_reg;
  assign stallreq_mem = d_ce & ~d_ack_reg;
  assign stallreq_if  = i_ce & ~i_ack_reg;

`ifdef MEM_ARB_TIMEOUT_EN
  assign err = err_reg;
`else
  // Without the timeout, the wait limit has no meaning and err is never set.
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT_CYCLES);
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter. The bench pushes the expected ack port and read data
// onto a scoreboard queue when the memory completes. An ack monitor pops the queue and
// compares the entry. The bench instantiates the DUT with TIMEOUT_CYCLES=4. The timeout
// scenario runs when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ce, d_ce, d_we, m_ready;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_sel;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_ack, d_ack, m_ce, m_we, stallreq_if, stallreq_mem, err;
  logic [3:0]  m_sel;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .i_ce(i_ce), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_ce(d_ce), .d_we(d_we), .d_addr(d_addr), .d_sel(d_sel), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_ce(m_ce), .m_we(m_we), .m_addr(m_addr), .m_sel(m_sel), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem), .err(err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
  } sb_t;
  sb_t sb_q[$];

  // Model of the held read-data registers
  logic [31:0] exp_i_rdata = 32'd0;
  logic [31:0] exp_d_rdata = 32'd0;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    bit          exp_we;
    logic [3:0]  exp_sel;
    logic [31:0] exp_wdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit is_d, input logic [31:0] rdata);
    sb_t e;
    e.is_d  = is_d;
    e.rdata = rdata;
    sb_q.push_back(e);
    if (is_d) exp_d_rdata = rdata;
    else      exp_i_rdata = rdata;
  endtask

  // Ack monitor: every ack must match the oldest expected completion.
  always @(negedge clk) begin
    if (i_ack || d_ack) begin
      sb_t e;
      if (i_ack && d_ack) begin
        checks++;
        errors++;
        $display("FAIL dual_ack: got both acks, expected one");
      end else if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got i_ack=%0b d_ack=%0b, expected none", i_ack, d_ack);
      end else begin
        e = sb_q.pop_front();
        check("ack_port", 32'(d_ack), 32'(e.is_d));
        check("ack_rdata", d_ack ? d_rdata : i_rdata, e.rdata);
        $display("txn t=%0t ack=%s rdata=0x%08h", $time, d_ack ? "D" : "I", d_ack ? d_rdata : i_rdata);
      end
    end
  end

  task automatic do_reset();
    tick();
    rst = 1'b1; i_ce = 1'b0; d_ce = 1'b0; m_ready = 1'b0;
    tick();
    @(negedge clk);
    check("rst_i_ack", 32'(i_ack), 32'd0);
    check("rst_d_ack", 32'(d_ack), 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_m_ce", 32'(m_ce), 32'd0);
    exp_i_rdata = 32'd0;
    exp_d_rdata = 32'd0;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] exp_rd;
    tick();
    m_ready = 1'b0;
    m_rdata = 32'hBAD0_0000;
    if (v.is_d) begin
      d_ce = 1'b1; d_we = v.we; d_addr = v.addr; d_sel = v.sel; d_wdata = v.wdata;
      i_ce = 1'b0; i_addr = 32'h7777_0000;
    end else begin
      i_ce = 1'b1; i_addr = v.addr;
      d_ce = 1'b0; d_we = 1'b1; d_addr = 32'hFFFF_FFF0; d_sel = 4'hA; d_wdata = 32'hA5A5_A5A5;
    end
    @(negedge clk);
    check("req_m_ce", 32'(m_ce), 32'd0);
    check("req_m_addr", m_addr, 32'd0);
    check("hold_i_rdata", i_rdata, exp_i_rdata);
    check("hold_d_rdata", d_rdata, exp_d_rdata);
    check("req_stall", 32'(v.is_d ? stallreq_mem : stallreq_if), 32'd1);
    for (int k = 0; k <= v.waits; k++) begin
      tick();
      m_ready = (k == v.waits);
      m_rdata = (k == v.waits) ? v.rdata : 32'h0BAD_0000 + 32'(k);
      @(negedge clk);
      check("grant_m_ce", 32'(m_ce), 32'd1);
      check("grant_m_we", 32'(m_we), 32'(v.exp_we));
      check("grant_m_addr", m_addr, v.addr);
      check("grant_m_sel", 32'(m_sel), 32'(v.exp_sel));
      check("grant_m_wdata", m_wdata, v.exp_wdata);
      check("grant_stall", 32'(v.is_d ? stallreq_mem : stallreq_if), 32'd1);
      if (k == v.waits) begin
        exp_rd = (v.is_d && v.we) ? exp_d_rdata : v.rdata;
        push_exp(v.is_d, exp_rd);
      end
    end
    tick();
    i_ce = 1'b0; d_ce = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    check("ack_pulse", 32'(v.is_d ? d_ack : i_ack), 32'd1);
    check("ack_m_ce", 32'(m_ce), 32'd0);
    tick();
    @(negedge clk);
    check("ack_one_cycle", 32'({i_ack, d_ack}), 32'd0);
  endtask

  vec_t vecs[5];

  initial begin
    rst = 1'b1; i_ce = 1'b0; d_ce = 1'b0; d_we = 1'b0; m_ready = 1'b0;
    i_addr = 32'd0; d_addr = 32'd0; d_sel = 4'd0; d_wdata = 32'd0; m_rdata = 32'd0;

    // {is_d, we, addr, sel, wdata, rdata, waits, exp_we, exp_sel, exp_wdata}
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0,       32'hDEAD_BEEF, 0, 1'b0, 4'hF, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_0200, 4'h0, 32'h0,       32'h0000_0013, 0, 1'b0, 4'hF, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0300, 4'h3, 32'h1234,    32'hFFFF_0000, 3, 1'b1, 4'h3, 32'h1234};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0204, 4'h0, 32'h0,       32'hCAFE_F00D, 2, 1'b0, 4'hF, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0104, 4'h4, 32'h9999,    32'h55AA_55AA, 1, 1'b0, 4'h4, 32'h9999};

    do_reset();

    for (int n = 0; n < 5; n++) begin
      run_vec(vecs[n]);
    end

    // Requester drops ce mid-access: the access still completes with an ack.
    tick();
    d_ce = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0500; d_sel = 4'hF; m_ready = 1'b0;
    tick();
    d_ce = 1'b0;
    @(negedge clk);
    check("drop_m_ce", 32'(m_ce), 32'd1);
    tick();
    m_ready = 1'b1; m_rdata = 32'h0BEE_F00D;
    @(negedge clk);
    check("drop_m_addr", m_addr, 32'h0000_0500);
    push_exp(1'b1, 32'h0BEE_F00D);
    tick();
    m_ready = 1'b0;
    @(negedge clk);
    check("drop_ack", 32'(d_ack), 32'd1);

    // Contention: both ports held, memory always ready -> D,I,D,I grants.
    do_reset();
    d_ce = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0400; d_sel = 4'hF;
    i_ce = 1'b1; i_addr = 32'h0000_0800; m_ready = 1'b1; m_rdata = 32'h1000_0000;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) begin
        tick();
        m_rdata = 32'h1000_0000 + 32'(c);
        if (c == 8) begin
          d_ce = 1'b0; i_ce = 1'b0;
        end
      end
      @(negedge clk);
      check("cont_m_ce", 32'(m_ce), 32'(c % 2));
      check("cont_d_ack", 32'(d_ack), 32'(c == 2 || c == 6));
      check("cont_i_ack", 32'(i_ack), 32'(c == 4 || c == 8));
      check("cont_stall_mem", 32'(stallreq_mem), 32'(c < 8 && c != 2 && c != 6));
      check("cont_stall_if", 32'(stallreq_if), 32'(c < 8 && c != 4));
      if (c % 2 == 1) begin
        check("cont_m_addr", m_addr, (c % 4 == 1) ? 32'h0000_0400 : 32'h0000_0800);
        push_exp(c % 4 == 1, 32'h1000_0000 + 32'(c));
      end
    end
    tick();
    m_ready = 1'b0;
    @(negedge clk);
    check("cont_end_m_ce", 32'(m_ce), 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Timeout: a fetch that never sees m_ready is aborted after 4 wait cycles.
    tick();
    i_ce = 1'b1; i_addr = 32'h0000_0A00; m_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      @(negedge clk);
      check("to_m_ce", 32'(m_ce), 32'd1);
      check("to_err_low", 32'(err), 32'd0);
      if (k == 4) push_exp(1'b0, 32'd0);
    end
    tick();
    i_ce = 1'b0;
    @(negedge clk);
    check("to_ack", 32'(i_ack), 32'd1);
    check("to_idle", 32'(m_ce), 32'd0);
    check("to_err_set", 32'(err), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      check("to_err_sticky", 32'(err), 32'd1);
    end
`else
    // Without the timeout, a fetch waits as long as the memory takes.
    tick();
    i_ce = 1'b1; i_addr = 32'h0000_0A00; m_ready = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 12) begin
        m_ready = 1'b1; m_rdata = 32'h0000_0A0A;
        push_exp(1'b0, 32'h0000_0A0A);
      end
      @(negedge clk);
      check("wait_m_ce", 32'(m_ce), 32'd1);
      check("wait_err", 32'(err), 32'd0);
    end
    tick();
    i_ce = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    check("wait_ack", 32'(i_ack), 32'd1);
`endif

    // Reset during the 2nd IGRANT cycle: the bus drops and no ack is issued.
    tick();
    i_ce = 1'b1; i_addr = 32'h0000_0900; m_ready = 1'b0; d_ce = 1'b0;
    tick();
    @(negedge clk);
    check("mid_grant1", 32'(m_ce), 32'd1);
    tick();
    rst = 1'b1; i_ce = 1'b0;
    @(negedge clk);
    check("mid_grant2", 32'(m_ce), 32'd1);
    tick();
    rst = 1'b0;
    exp_i_rdata = 32'd0;
    exp_d_rdata = 32'd0;
    @(negedge clk);
    check("mid_m_ce", 32'(m_ce), 32'd0);
    check("mid_m_addr", m_addr, 32'd0);
    check("mid_m_sel", 32'(m_sel), 32'd0);
    check("mid_acks", 32'({i_ack, d_ack}), 32'd0);
    check("mid_i_rdata", i_rdata, 32'd0);
    check("mid_d_rdata", d_rdata, 32'd0);
    check("mid_err", 32'(err), 32'd0);
    tick();
    @(negedge clk);
    check("mid_no_ack", 32'({i_ack, d_ack}), 32'd0);
    check("mid_still_idle", 32'(m_ce), 32'd0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: bus-wait cycles before abort; used only with MEM_ARB_TIMEOUT_EN.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_ce  in  1  instruction-fetch request.
REQ-005 SHALL have port i_addr  in  32  fetch word address.
REQ-006 SHALL have port i_rdata  out  32  fetched word, registered.
REQ-007 SHALL have port i_ack  out  1  one-cycle fetch completion pulse.
REQ-008 SHALL have ports d_ce in 1, d_we in 1, d_addr in 32, d_sel in 4, d_wdata in 32, which form the MEM-stage load/store request.
REQ-009 SHALL have port d_rdata  out  32  load data, registered.
REQ-010 SHALL have port d_ack  out  1  one-cycle data completion pulse.
REQ-011 SHALL have ports m_ce out 1, m_we out 1, m_addr out 32, m_sel out 4, m_wdata out 32, which form the shared memory bus request.
REQ-012 SHALL have ports m_rdata in 32 and m_ready in 1, which carry memory response data and completion.
REQ-013 SHALL have ports stallreq_if out 1 and stallreq_mem out 1, which are pipeline stall requests.
REQ-014 SHALL have port err  out  1  sticky bus-timeout flag.

Function
REQ-015 SHALL implement states IDLE, DGRANT, IGRANT; state, last_grant and acks SHALL be registered.
REQ-016 In IDLE with d_ce=1 and i_ce=0, SHALL enter DGRANT; with i_ce=1 and d_ce=0, SHALL enter IGRANT; with neither set, SHALL stay in IDLE.
REQ-017 In IDLE with both d_ce=1 and i_ce=1, SHALL grant the port opposite last_grant; after reset last_grant=I, so data wins first.
REQ-018 In DGRANT, m_ce=1 and m_we/m_addr/m_sel/m_wdata SHALL equal the d_* inputs combinationally.
REQ-019 In IGRANT, m_ce=1, m_we=0, m_sel=4'b1111, m_addr=i_addr and m_wdata=0.
REQ-020 In IDLE, SHALL drive m_ce=0, m_we=0, m_sel=0, m_addr=0 and m_wdata=0.
REQ-021 On a grant-state cycle with m_ready=1, SHALL capture m_rdata into the granted port's rdata, pulse that port's ack on the next cycle, update last_grant, and return to IDLE.
REQ-022 For a store, d_rdata SHALL be unchanged and d_ack SHALL still pulse.
REQ-023 Minimum latency from request to ack SHALL be 2 cycles: IDLE->grant takes 1 edge, and m_ready in the first grant cycle produces ack at the next edge.
REQ-024 No new grant SHALL be issued in the cycle ack is high, because the state is IDLE then and arbitration occurs that cycle; back-to-back accesses therefore take 2 cycles each.
REQ-025 A started bus access SHALL never be aborted by its requester dropping ce; the ack SHALL pulse regardless.
REQ-026 stallreq_mem SHALL equal d_ce & ~d_ack, and stallreq_if SHALL equal i_ce & ~i_ack, both combinational.
REQ-027 rdata registers SHALL hold their value until the next completed read on the same port.

Reset
REQ-028 On rst=1 at a clock edge, SHALL set state=IDLE, last_grant=I, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0 and err=0.
REQ-029 Reset mid-access SHALL drop m_ce to 0 in the cycle after the reset edge; no ack SHALL be issued for the interrupted access.

Configuration
REQ-030 With MEM_ARB_TIMEOUT_EN defined, an 8-bit-or-wider wait counter SHALL clear on grant entry and increment each grant cycle with m_ready=0.
REQ-031 With MEM_ARB_TIMEOUT_EN defined and the counter reaching TIMEOUT_CYCLES, SHALL return to IDLE, pulse the granted ack with rdata=0, and set err until rst.
REQ-032 Without MEM_ARB_TIMEOUT_EN, a grant SHALL wait indefinitely for m_ready, no counter SHALL exist, and err SHALL be tied to 0.

Verification
REQ-033 Single load: d_ce=1, d_we=0, d_addr=0x100, m_ready=1 on first grant cycle, m_rdata=0xDEADBEEF -> d_ack at cycle 2, d_rdata=0xDEADBEEF, stallreq_mem high for cycles 0-1.
REQ-034 Contention: i_ce=d_ce=1 held continuously, m_ready=1 always -> grants alternate D,I,D,I; ack pulses every 2 cycles.
REQ-035 Wait states: d_ce=1, d_we=1, d_sel=4'b0011, d_wdata=0x1234, m_ready low for 3 grant cycles -> m_* stable for 4 cycles, d_ack one cycle after m_ready, d_rdata unchanged.
REQ-036 Reset mid-access: rst pulsed in the 2nd IGRANT cycle -> m_ce=0 in the next cycle, no i_ack, all outputs 0.
REQ-037 Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): fetch with m_ready=0 forever -> i_ack after 4 wait cycles, i_rdata=0, err=1 until rst.
